// File: rtl/snn_layer_core.sv
// Time-multiplexed LIF layer: streams N_IN weight rows from a sync-read SRAM,
// accumulates with saturation, then leaks, fires and resets N_NEU neurons per timestep.
module snn_layer_core #(
  parameter int N_NEU      = 16,
  parameter int N_IN       = 128,
  parameter int W_BITS     = 2,
  parameter int U_BITS     = 8,
  parameter int BETA_SHIFT = 3,
  parameter int RESET_MODE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                num_steps,
  input  logic [U_BITS-1:0]         threshold,
  input  logic [N_IN-1:0]           in_spk,
  input  logic                      in_spk_valid,
  output logic                      in_spk_ready,
  output logic [$clog2(N_IN)-1:0]   w_addr,
  input  logic [N_NEU*W_BITS-1:0]   w_data,
  output logic [N_NEU-1:0]          spk_out,
  output logic                      spk_valid,
  output logic [N_NEU*U_BITS-1:0]   u_out,
  output logic                      busy,
  output logic                      done
);
  localparam int AW = $clog2(N_IN);
  localparam int KW = $clog2(N_IN + 1);
  localparam int SW = U_BITS + 2;
  localparam logic [KW-1:0] K_LAST = KW'(N_IN);
  localparam logic signed [SW-1:0] S_MAX = SW'((1 << (U_BITS - 1)) - 1);
  localparam logic signed [SW-1:0] S_MIN = SW'(-(1 << (U_BITS - 1)));

  typedef enum logic [2:0] {IDLE, WAIT_IN, ACC, FIRE, OUT} state_t;
  state_t state, state_nxt;

  logic [KW-1:0]            k;
  logic [7:0]               step;
  logic [7:0]               steps_m1;
  logic signed [U_BITS-1:0] thr;
  logic [N_IN-1:0]          spk_sh;
  logic signed [U_BITS-1:0] u       [N_NEU];
  logic signed [U_BITS-1:0] acc     [N_NEU];
  logic signed [U_BITS-1:0] acc_add [N_NEU];
  logic signed [U_BITS-1:0] un      [N_NEU];
  logic signed [U_BITS-1:0] u_fire  [N_NEU];
  logic [N_NEU-1:0]         spk_fire;
  logic                     last_step;

  function automatic logic signed [U_BITS-1:0] sat(input logic signed [SW-1:0] x);
    if (x > S_MAX) return S_MAX[U_BITS-1:0];
    if (x < S_MIN) return S_MIN[U_BITS-1:0];
    return x[U_BITS-1:0];
  endfunction

  assign last_step = (step == steps_m1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    in_spk_ready = 1'b0;
    spk_valid    = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    w_addr       = '0;
    case (state)
      IDLE:    if (start) state_nxt = WAIT_IN;
      WAIT_IN: begin
        in_spk_ready = 1'b1;
        if (in_spk_valid) state_nxt = ACC;
      end
      ACC: begin
        if (k != K_LAST) w_addr = k[AW-1:0];
        else             state_nxt = FIRE;
      end
      FIRE:    state_nxt = OUT;
      OUT: begin
        spk_valid = 1'b1;
        done      = last_step;
        state_nxt = last_step ? IDLE : WAIT_IN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Widen to U_BITS+2 before summing so leak+acc and un-threshold cannot wrap before saturation.
  always_comb begin
    spk_fire = '0;
    acc_add  = '{default: '0};
    un       = '{default: '0};
    u_fire   = '{default: '0};
    for (int unsigned n = 0; n < N_NEU; n++) begin
      acc_add[n] = sat(SW'(acc[n]) + SW'($signed(w_data[n*W_BITS +: W_BITS])));
      un[n]      = sat(SW'(u[n]) - SW'(u[n] >>> BETA_SHIFT) + SW'(acc[n]));
      spk_fire[n] = (un[n] >= thr);
      if (!spk_fire[n])         u_fire[n] = un[n];
      else if (RESET_MODE == 0) u_fire[n] = sat(SW'(un[n]) - SW'(thr));
      else                      u_fire[n] = '0;
    end
  end

  // Row k-1 arrives on cycle k; the latched spike vector is shifted so bit 0 always matches it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k        <= '0;
      step     <= '0;
      steps_m1 <= '0;
      thr      <= '0;
      spk_sh   <= '0;
      spk_out  <= '0;
      u_out    <= '0;
      for (int unsigned n = 0; n < N_NEU; n++) begin
        u[n]   <= '0;
        acc[n] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          steps_m1 <= (num_steps == 8'd0) ? 8'd0 : num_steps - 8'd1;
          thr      <= threshold;
          step     <= '0;
          for (int unsigned n = 0; n < N_NEU; n++) u[n] <= '0;
        end
        WAIT_IN: if (in_spk_valid) begin
          spk_sh <= in_spk;
          k      <= '0;
          for (int unsigned n = 0; n < N_NEU; n++) acc[n] <= '0;
        end
        ACC: begin
          k <= k + KW'(1);
          if (k != '0) begin
            spk_sh <= spk_sh >> 1;
            if (spk_sh[0])
              for (int unsigned n = 0; n < N_NEU; n++) acc[n] <= acc_add[n];
          end
        end
        FIRE: begin
          spk_out <= spk_fire;
          for (int unsigned n = 0; n < N_NEU; n++) begin
            u[n]                        <= u_fire[n];
            u_out[n*U_BITS +: U_BITS]   <= u_fire[n];
          end
        end
        OUT: if (!last_step) step <= step + 8'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_snn_layer_core.sv
// Bench for snn_layer_core: both reset modes side by side against an integer LIF model,
// directed corner runs plus randomized weights, spikes, thresholds and handshake gaps.
module tb_snn_layer_core;
  localparam int N_NEU  = 16;
  localparam int N_IN   = 128;
  localparam int W_BITS = 2;
  localparam int U_BITS = 8;
  localparam int AW     = $clog2(N_IN);
  localparam int UW     = N_NEU * U_BITS;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [7:0] num_steps = '0;
  logic [U_BITS-1:0] threshold = '0;
  logic [N_IN-1:0] in_spk = '0;
  logic in_spk_valid = 1'b0;

  logic rdy0, rdy1, sv0, sv1, busy0, busy1, done0, done1;
  logic [AW-1:0] wa0, wa1;
  logic [N_NEU*W_BITS-1:0] wd0, wd1;
  logic [N_NEU-1:0] so0, so1;
  logic [UW-1:0] uo0, uo1;

  logic [N_NEU*W_BITS-1:0] mem [N_IN];

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int mu [2][N_NEU];
  int obs_u [8];

  snn_layer_core #(.N_NEU(N_NEU), .N_IN(N_IN), .W_BITS(W_BITS), .U_BITS(U_BITS),
                   .BETA_SHIFT(3), .RESET_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .num_steps(num_steps), .threshold(threshold),
    .in_spk(in_spk), .in_spk_valid(in_spk_valid), .in_spk_ready(rdy0), .w_addr(wa0),
    .w_data(wd0), .spk_out(so0), .spk_valid(sv0), .u_out(uo0), .busy(busy0), .done(done0));

  snn_layer_core #(.N_NEU(N_NEU), .N_IN(N_IN), .W_BITS(W_BITS), .U_BITS(U_BITS),
                   .BETA_SHIFT(3), .RESET_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .num_steps(num_steps), .threshold(threshold),
    .in_spk(in_spk), .in_spk_valid(in_spk_valid), .in_spk_ready(rdy1), .w_addr(wa1),
    .w_data(wd1), .spk_out(so1), .spk_valid(sv1), .u_out(uo1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    wd0 <= mem[wa0];
    wd1 <= mem[wa1];
  end

  always @(negedge clk) if (sv0) pulses++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int wt(input int k, input int n);
    logic [W_BITS-1:0] b;
    b = mem[k][n*W_BITS +: W_BITS];
    return int'($signed(b));
  endfunction

  task automatic fill_mem(input int kind);
    for (int k = 0; k < N_IN; k++)
      case (kind)
        0:       mem[k] = $urandom;
        1:       mem[k] = {N_NEU{2'b01}};
        default: mem[k] = {N_NEU{2'b10}};
      endcase
  endtask

  // One timestep of the layer in plain integers, for both reset modes.
  task automatic model_step(input logic [N_IN-1:0] v, input int thr,
                            output logic [N_NEU-1:0] s0, output logic [N_NEU-1:0] s1,
                            output logic [UW-1:0] e0, output logic [UW-1:0] e1);
    int a, unv, t;
    s0 = '0; s1 = '0; e0 = '0; e1 = '0;
    for (int n = 0; n < N_NEU; n++) begin
      a = 0;
      for (int k = 0; k < N_IN; k++) if (v[k]) a = sat(a + wt(k, n));
      for (int m = 0; m < 2; m++) begin
        unv = sat(mu[m][n] - (mu[m][n] >>> 3) + a);
        if (unv >= thr) begin
          mu[m][n] = (m == 0) ? sat(unv - thr) : 0;
          if (m == 0) s0[n] = 1'b1; else s1[n] = 1'b1;
        end else begin
          mu[m][n] = unv;
        end
        t = mu[m][n];
        if (m == 0) e0[n*U_BITS +: U_BITS] = t[U_BITS-1:0];
        else        e1[n*U_BITS +: U_BITS] = t[U_BITS-1:0];
      end
    end
  endtask

  // pat: 0 random spikes, 1 all ones, 2 first step 64 low spikes then silence.
  task automatic run(input int steps, input int thr, input int dly, input int pat, input bit noisy);
    int eff, lat, tmo, base;
    logic [N_IN-1:0] v;
    logic [N_NEU-1:0] es0, es1;
    logic [UW-1:0] eu0, eu1;
    eff  = (steps == 0) ? 1 : steps;
    base = pulses;
    num_steps = 8'(steps);
    threshold = U_BITS'(thr);
    start = 1'b1;
    tick();
    start = 1'b0;
    num_steps = 8'($urandom);
    threshold = U_BITS'($urandom);
    check("busy_after_start", {busy0, busy1}, 2'b11);
    for (int m = 0; m < 2; m++) for (int n = 0; n < N_NEU; n++) mu[m][n] = 0;
    for (int s = 0; s < eff; s++) begin
      for (int d = 0; d < dly; d++) begin
        if (noisy) start = 1'($urandom_range(0, 1));
        tick();
      end
      start = 1'b0;
      case (pat)
        0:       v = {$urandom, $urandom, $urandom, $urandom};
        1:       v = '1;
        default: v = (s == 0) ? {{(N_IN-64){1'b0}}, {64{1'b1}}} : '0;
      endcase
      in_spk = v;
      in_spk_valid = 1'b1;
      tmo = 0;
      while (!rdy0 && tmo < 50) begin tick(); tmo++; end
      check("ready_wait", 1'(tmo < 50), 1'b1);
      tick();
      in_spk_valid = 1'b0;
      in_spk = {$urandom, $urandom, $urandom, $urandom};
      lat = 1;
      while (!sv0 && lat < N_IN + 10) begin
        in_spk_valid = (lat >= 3 && lat < 8);
        if (noisy) start = 1'($urandom_range(0, 1));
        tick();
        lat++;
      end
      in_spk_valid = 1'b0;
      start = noisy;
      check("latency", lat, N_IN + 3);
      model_step(v, thr, es0, es1, eu0, eu1);
      check("spk_out_m0", so0, es0);
      check("u_out_m0", uo0, eu0);
      check("spk_out_m1", so1, es1);
      check("u_out_m1", uo1, eu1);
      check("done", {done0, done1}, {2{1'(s == eff - 1)}});
      check("w_addr_idle", wa0, '0);
      obs_u[s] = int'($signed(uo0[U_BITS-1:0]));
      tick();
      start = 1'b0;
      check("spk_valid_pulse", {sv0, sv1}, 2'b00);
    end
    check("busy_end", {busy0, busy1}, 2'b00);
    repeat (5) tick();
    check("pulse_count", pulses - base, eff);
    check("stay_idle", busy0, 1'b0);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", {busy0, busy1}, 2'b00);
    check("rst_valid", {sv0, done0, rdy0}, 3'b000);
    check("rst_u_out", uo0, '0);
    reset = 1'b1;
    tick();

    fill_mem(1);
    run(1, 100, 0, 1, 0);
    check("sat_spk", so0, {N_NEU{1'b1}});
    check("sat_u_m0", uo0, {N_NEU{8'd27}});
    check("sat_u_m1", uo1, '0);

    num_steps = 8'd2;
    threshold = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_spk = '1;
    in_spk_valid = 1'b1;
    tick();
    in_spk_valid = 1'b0;
    repeat (20) tick();
    check("acc_w_addr_live", 1'(wa0 != '0), 1'b1);
    #2 reset = 1'b0;
    #1;
    check("midrun_rst_busy", {busy0, busy1}, 2'b00);
    check("midrun_rst_valid", {sv0, sv1}, 2'b00);
    check("midrun_rst_w_addr", wa0, '0);
    check("midrun_rst_u_out", uo0, '0);
    tick();
    reset = 1'b1;
    tick();

    run(4, 127, 0, 2, 0);
    check("leak_s0", obs_u[0], 64);
    check("leak_s1", obs_u[1], 56);
    check("leak_s2", obs_u[2], 49);
    check("leak_s3", obs_u[3], 43);

    fill_mem(2);
    run(2, 100, 0, 1, 0);
    check("neg_u", uo0, {N_NEU{8'h80}});
    check("neg_spk", so0, '0);

    fill_mem(0);
    run(3, 20, 10, 0, 0);
    run(0, 10, 2, 0, 1);

    for (int i = 0; i < 6; i++) begin
      fill_mem(0);
      run($urandom_range(1, 4), int'($urandom_range(0, 80)) - 20, $urandom_range(0, 3), 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
